color_scan_sched: RTL and testbench
===================================

# color_scan_sched

Frame-synchronous scheduler for the colour-threshold detection pipeline. The binarisation, morphology, shape and box stages share one colour threshold, so the block time-multiplexes that pipeline across up to four target colours. It drives the colour select and holds it stable for whole frames, and it discards the settle frames that follow each colour change. It then waits for a detection verdict, or times out, and reports one result record per colour. It sits between the camera frame timing and the colour select / detection status of the image processing top.

## Interface
Parameters
- NUM_COLOR, 3: colours scanned per sweep, legal 1..4; colour codes 0..NUM_COLOR-1.
- SETTLE_FRAMES, 1: frame ends ignored after each colour change, legal 0..15.
- TIMEOUT_FRAMES, 2: frame ends allowed in WAIT before a no-target verdict, legal 1..15.

Ports
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a sweep; ignored while busy.
- stop  in  1  synchronous abort; has priority over every other input.
- cont  in  1  1 = restart the sweep at colour 0 after the last colour; sampled in REPORT.
- frame_eop  in  1  end-of-frame strobe of the pipeline input stream.
- detect_finish  in  1  detection-complete flag from the box stage.
- target_is_invalid  in  1  no-target flag from the shape stage.
- shape_in  in  3  shape code, valid while detect_finish is high.
- x_center, y_center  in  9 each  target centre, valid while detect_finish is high.
- color_sel  out  2  colour select to the binariser.
- busy  out  1  high in every state except IDLE.
- res_vld  out  1  one-cycle result strobe.
- res_color  out  2  colour code of the result.
- res_found  out  1  1 = target detected.
- res_timeout  out  1  1 = verdict came from timeout.
- res_shape  out  3, res_x  out  9, res_y  out  9  captured detection data; all zero when res_found=0.
- found_mask  out  4  bit c set when colour c was found in the current sweep.
- sweep_done  out  1  one-cycle strobe, coincident with the res_vld of the last colour.

## Operation
- States: IDLE, SYNC, SETTLE, WAIT, REPORT, NEXT.
- IDLE
  - On start, go to SYNC.
- SYNC
  - On frame_eop: color_sel<=0, found_mask<=0.
  - Go to SETTLE, or to WAIT when SETTLE_FRAMES=0.
- SETTLE
  - A 4-bit frame counter, cleared on entry, counts frame_eop.
  - Go to WAIT on the SETTLE_FRAMES-th frame_eop.
  - Detection inputs are ignored in this state.
- WAIT
  - Rising-edge detectors on detect_finish and target_is_invalid (previous-value registers reset to 0, updated every cycle in all states). Only a 0->1 transition seen in WAIT qualifies.
  - detect_finish edge: capture shape_in, x_center and y_center; found=1; go to REPORT.
  - target_is_invalid edge without a detect_finish edge in the same cycle: found=0; go to REPORT.
  - Otherwise, on the TIMEOUT_FRAMES-th frame_eop (counter cleared on WAIT entry): found=0, timeout=1; go to REPORT.
  - Priority within one cycle: detect_finish edge > invalid edge > timeout.
- REPORT, one cycle
  - res_vld=1; res_* show the verdict; found_mask[color_sel] is set if found.
  - Last colour (color_sel = NUM_COLOR-1): sweep_done=1; go to SYNC if cont=1, else to IDLE.
  - Not the last colour: go to NEXT.
- NEXT
  - On frame_eop: color_sel<=color_sel+1.
  - Go to SETTLE, or to WAIT when SETTLE_FRAMES=0.
- color_sel changes only in the cycle after a sampled frame_eop, so it is constant for every full frame.
- stop in any state: go to IDLE next cycle. No res_vld or sweep_done is issued; color_sel and found_mask are held.
- start while busy has no effect.
- frame_eop arriving in the same cycle as the state entry is not counted by the new state.

## Timing
- Reset values: color_sel=0, busy=0, res_vld=0, res_color=0, res_found=0, res_timeout=0, res_shape=0, res_x=0, res_y=0, found_mask=0, sweep_done=0.
- All outputs are registered.
- busy rises 1 cycle after the start strobe and falls 1 cycle after the REPORT in which the sweep ends (cont=0), or 1 cycle after stop.
- Latency from a qualifying edge seen at cycle N: res_vld high at cycle N+1 for exactly one cycle. The captured data are the input values at cycle N.
- res_* values hold after res_vld falls until the next REPORT.
- color_sel update latency: frame_eop sampled at cycle N gives the new color_sel at cycle N+1.
- Colour code arithmetic is 2-bit. The wrap from NUM_COLOR-1 to 0 happens only through SYNC, never through an increment.

## Test plan
- NUM_COLOR=3, SETTLE_FRAMES=1, cont=0; start, then detect_finish pulses in WAIT of each colour with shape 3'd2 and x,y = 9'd100, 9'd50 -> three res_vld pulses with res_color 0,1,2, each with found=1, shape 2 and x,y = 100,50; sweep_done with the third; found_mask=4'b0111; busy falls.
- detect_finish pulse during SETTLE, with no further events -> ignored; res_timeout=1 and res_found=0 after 2 WAIT frame ends.
- detect_finish and target_is_invalid edges in the same WAIT cycle -> res_found=1.
- target_is_invalid held high across the colour change -> no verdict in the new WAIT until a new rising edge arrives.
- cont=1 -> after sweep_done, the next frame_eop gives color_sel=0 and found_mask=0; sweeps repeat.
- stop asserted mid-WAIT at colour 1 -> IDLE next cycle, no res_vld, color_sel stays 1. A start during a sweep changes nothing. Reset mid-sweep -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/color_scan_sched.sv
// color_scan_sched: frame-synchronous colour scheduler for the shared
// colour-threshold detection pipeline. Steps the colour select through up to
// four colours, discards settle frames after each change, waits for a
// detection verdict (or times out) and emits one result record per colour.
//
// Ports
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   start, stop, cont     sweep control (stop has priority over everything)
//   frame_eop             end-of-frame strobe of the pipeline input stream
//   detect_finish         detection-complete flag (rising edge = found)
//   target_is_invalid     no-target flag (rising edge = not found)
//   shape_in, x_center,
//   y_center              detection data, captured on the detect_finish edge
//   color_sel             colour select to the binariser, stable per frame
//   busy                  high whenever the scheduler is not idle
//   res_vld, res_*        one-cycle result strobe and held result record
//   found_mask            per-colour found bits of the current sweep
//   sweep_done            strobe coincident with the last colour's result
module color_scan_sched #(
  parameter int unsigned NUM_COLOR      = 3,
  parameter int unsigned SETTLE_FRAMES  = 1,
  parameter int unsigned TIMEOUT_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic       frame_eop,
  input  logic       detect_finish,
  input  logic       target_is_invalid,
  input  logic [2:0] shape_in,
  input  logic [8:0] x_center,
  input  logic [8:0] y_center,
  output logic [1:0] color_sel,
  output logic       busy,
  output logic       res_vld,
  output logic [1:0] res_color,
  output logic       res_found,
  output logic       res_timeout,
  output logic [2:0] res_shape,
  output logic [8:0] res_x,
  output logic [8:0] res_y,
  output logic [3:0] found_mask,
  output logic       sweep_done
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned COLOR_W = 2;
  localparam int unsigned SHAPE_W = 3;
  localparam int unsigned COORD_W = 9;
  localparam int unsigned MASK_W  = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;

  localparam logic [COLOR_W-1:0] COLOR_LAST = COLOR_W'(NUM_COLOR - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST =
    (SETTLE_FRAMES == 0) ? '0 : CNT_W'(SETTLE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
  // State entered after every colour change (skips SETTLE when no settle frames)
  localparam logic [2:0]         ST_AFTER_CHANGE =
    (SETTLE_FRAMES == 0) ? ST_WAIT : ST_SETTLE;

  logic [2:0]         state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [COLOR_W-1:0] color_q,     color_d;
  logic [MASK_W-1:0]  mask_q,      mask_d;
  logic               busy_q,      busy_d;
  logic               res_vld_q,   res_vld_d;
  logic [COLOR_W-1:0] res_color_q, res_color_d;
  logic               res_found_q, res_found_d;
  logic               res_to_q,    res_to_d;
  logic [SHAPE_W-1:0] res_shape_q, res_shape_d;
  logic [COORD_W-1:0] res_x_q,     res_x_d;
  logic [COORD_W-1:0] res_y_q,     res_y_d;
  logic               sweep_q,     sweep_d;
  logic               df_prev_q;
  logic               inv_prev_q;

  logic               df_rise;
  logic               inv_rise;

  // Edge detectors run in every state; only WAIT acts on them.
  assign df_rise  = detect_finish & ~df_prev_q;
  assign inv_rise = target_is_invalid & ~inv_prev_q;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      color_q     <= '0;
      mask_q      <= '0;
      busy_q      <= 1'b0;
      res_vld_q   <= 1'b0;
      res_color_q <= '0;
      res_found_q <= 1'b0;
      res_to_q    <= 1'b0;
      res_shape_q <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      sweep_q     <= 1'b0;
      df_prev_q   <= 1'b0;
      inv_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      color_q     <= color_d;
      mask_q      <= mask_d;
      busy_q      <= busy_d;
      res_vld_q   <= res_vld_d;
      res_color_q <= res_color_d;
      res_found_q <= res_found_d;
      res_to_q    <= res_to_d;
      res_shape_q <= res_shape_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      sweep_q     <= sweep_d;
      df_prev_q   <= detect_finish;
      inv_prev_q  <= target_is_invalid;
    end
  end

  // Next-state and next-output logic. The verdict is registered on the
  // WAIT->REPORT edge so res_vld is high exactly while the FSM is in REPORT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    color_d     = color_q;
    mask_d      = mask_q;
    res_vld_d   = 1'b0;
    res_color_d = res_color_q;
    res_found_d = res_found_q;
    res_to_d    = res_to_q;
    res_shape_d = res_shape_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    sweep_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (frame_eop) begin
          color_d = '0;
          mask_d  = '0;
          cnt_d   = '0;
          state_d = ST_AFTER_CHANGE;
        end
      end

      ST_SETTLE: begin
        if (frame_eop) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_WAIT: begin
        if (df_rise || inv_rise ||
            (frame_eop && (cnt_q == TIMEOUT_LAST))) begin
          state_d     = ST_REPORT;
          res_vld_d   = 1'b1;
          res_color_d = color_q;
          sweep_d     = (color_q == COLOR_LAST);
          // Detect edge wins over invalid edge, which wins over timeout.
          res_found_d = df_rise;
          res_to_d    = ~df_rise & ~inv_rise;
          res_shape_d = df_rise ? shape_in : '0;
          res_x_d     = df_rise ? x_center : '0;
          res_y_d     = df_rise ? y_center : '0;
          if (df_rise) begin
            mask_d = mask_q | (MASK_W'(1) << color_q);
          end
        end else if (frame_eop) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_REPORT: begin
        if (color_q == COLOR_LAST) begin
          state_d = cont ? ST_SYNC : ST_IDLE;
        end else begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (frame_eop) begin
          color_d = color_q + COLOR_W'(1);
          cnt_d   = '0;
          state_d = ST_AFTER_CHANGE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: back to IDLE, nothing reported, colour and mask held.
    if (stop) begin
      state_d     = ST_IDLE;
      cnt_d       = cnt_q;
      color_d     = color_q;
      mask_d      = mask_q;
      res_vld_d   = 1'b0;
      res_color_d = res_color_q;
      res_found_d = res_found_q;
      res_to_d    = res_to_q;
      res_shape_d = res_shape_q;
      res_x_d     = res_x_q;
      res_y_d     = res_y_q;
      sweep_d     = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign color_sel   = color_q;
  assign busy        = busy_q;
  assign res_vld     = res_vld_q;
  assign res_color   = res_color_q;
  assign res_found   = res_found_q;
  assign res_timeout = res_to_q;
  assign res_shape   = res_shape_q;
  assign res_x       = res_x_q;
  assign res_y       = res_y_q;
  assign found_mask  = mask_q;
  assign sweep_done  = sweep_q;

endmodule

// File: tb/tb_color_scan_sched.sv
// Testbench for color_scan_sched: directed result table, multi-frame corner
// sequences and a randomized run checked against a frame-level model.
module tb_color_scan_sched;

  localparam int NC = 3;
  localparam int SF = 1;
  localparam int TF = 2;
  localparam int FL = 8;   // cycles per frame; eop on the last cycle

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, cont = 1'b0, frame_eop = 1'b0;
  logic       detect_finish = 1'b0, target_is_invalid = 1'b0;
  logic [2:0] shape_in = '0;
  logic [8:0] x_center = '0, y_center = '0;
  logic [1:0] color_sel, res_color;
  logic       busy, res_vld, res_found, res_timeout, sweep_done;
  logic [2:0] res_shape;
  logic [8:0] res_x, res_y;
  logic [3:0] found_mask;

  always #5 clk = ~clk;

  color_scan_sched #(.NUM_COLOR(NC), .SETTLE_FRAMES(SF), .TIMEOUT_FRAMES(TF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .frame_eop(frame_eop), .detect_finish(detect_finish),
    .target_is_invalid(target_is_invalid), .shape_in(shape_in),
    .x_center(x_center), .y_center(y_center), .color_sel(color_sel),
    .busy(busy), .res_vld(res_vld), .res_color(res_color),
    .res_found(res_found), .res_timeout(res_timeout), .res_shape(res_shape),
    .res_x(res_x), .res_y(res_y), .found_mask(found_mask),
    .sweep_done(sweep_done)
  );

  typedef struct {
    logic [1:0] color;
    logic       found;
    logic       to;
    logic [2:0] shape;
    logic [8:0] x;
    logic [8:0] y;
    logic       sweep;
    logic [3:0] mask;
  } exp_t;

  typedef struct {
    bit         first;
    bit         settle_pulse;
    int         evt;      // 0 none, 1 detect, 2 invalid, 3 both
    int         wf;       // wait frame carrying the event
    logic [2:0] sh;
    logic [8:0] x;
    logic [8:0] y;
    exp_t       e;
  } row_t;

  exp_t       exp_q[$];
  exp_t       got;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  bit         busy_chk_en = 1'b0;
  bit         busy_exp = 1'b0;
  bit         cont_f = 1'b0;
  logic [2:0] pk_shape = '0;
  logic [8:0] pk_x = '0, pk_y = '0;
  logic [1:0] prev_sel = '0;
  logic       prev_eop = 1'b0;
  bit         mask_pend = 1'b0;
  logic [3:0] mask_req = '0;

  // frame-level model state
  bit         m_act = 1'b0, m_win = 1'b0;
  int         m_skip = 0, m_wfr = 0;
  logic [1:0] m_col = '0;
  logic [3:0] m_mask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] c, input logic f, input logic t,
                          input logic [2:0] sh, input logic [8:0] x,
                          input logic [8:0] y, input logic sw, input logic [3:0] m);
    exp_t e;
    e.color = c; e.found = f; e.to = t; e.shape = sh; e.x = x; e.y = y;
    e.sweep = sw; e.mask = m;
    exp_q.push_back(e);
  endtask

  // Result monitor: every res_vld must match the next expected record.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mask_pend) begin
        chk("found_mask_after_sweep", 32'(found_mask), 32'(mask_req));
        mask_pend = 1'b0;
      end
      if (color_sel != prev_sel)
        chk("color_sel_change_follows_eop", 32'(prev_eop), 32'd1);
      if (res_vld) begin
        chk("res_vld_was_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          chk("res_color", 32'(res_color), 32'(got.color));
          chk("res_found", 32'(res_found), 32'(got.found));
          chk("res_timeout", 32'(res_timeout), 32'(got.to));
          chk("res_shape", 32'(res_shape), 32'(got.shape));
          chk("res_x", 32'(res_x), 32'(got.x));
          chk("res_y", 32'(res_y), 32'(got.y));
          chk("sweep_done", 32'(sweep_done), 32'(got.sweep));
          if (got.sweep) begin
            mask_pend = 1'b1;
            mask_req  = got.mask;
          end
        end
      end else if (sweep_done) begin
        chk("sweep_done_needs_res_vld", 32'(res_vld), 32'd1);
      end
    end else begin
      mask_pend = 1'b0;
    end
    prev_sel = color_sel;
    prev_eop = frame_eop;
  end

  // One frame of FL cycles. Entered and left just after a rising edge.
  task automatic run_frame(input bit st, input bit dp, input bit ip,
                           input int inv_from, input bit sp);
    for (int c = 0; c < FL; c++) begin
      start             = st && (c == 1);
      stop              = sp && (c == 2);
      frame_eop         = (c == FL - 1);
      detect_finish     = dp && (c == 3);
      target_is_invalid = (ip && (c == 3)) || (c >= inv_from);
      if (c == 2) cont = cont_f;
      if (c == 3) begin
        shape_in = pk_shape; x_center = pk_x; y_center = pk_y;
      end else begin
        shape_in = 3'($urandom); x_center = 9'($urandom); y_center = 9'($urandom);
      end
      @(negedge clk);
      if (busy_chk_en && (c == 6)) chk("busy_vs_model", 32'(busy), 32'(busy_exp));
      @(posedge clk);
      #1;
    end
    start = 1'b0; stop = 1'b0; frame_eop = 1'b0; detect_finish = 1'b0;
  endtask

  // Model: a verdict for the current colour, then advance the sweep.
  task automatic model_verdict(input bit f, input bit t);
    if (f) m_mask = m_mask | (4'b0001 << m_col);
    push_exp(m_col, f, t, f ? pk_shape : 3'd0, f ? pk_x : 9'd0, f ? pk_y : 9'd0,
             m_col == 2'(NC - 1), m_mask);
    if (m_col == 2'(NC - 1)) begin
      if (cont_f) begin
        m_col = '0; m_mask = '0;
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_col = m_col + 2'd1;
    end
  endtask

  row_t tbl [6];

  initial begin
    // 1) reset values
    #12;
    chk("rst_color_sel", 32'(color_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_vld", 32'(res_vld), 32'd0);
    chk("rst_res_color", 32'(res_color), 32'd0);
    chk("rst_res_found", 32'(res_found), 32'd0);
    chk("rst_res_timeout", 32'(res_timeout), 32'd0);
    chk("rst_res_shape", 32'(res_shape), 32'd0);
    chk("rst_res_x", 32'(res_x), 32'd0);
    chk("rst_res_y", 32'(res_y), 32'd0);
    chk("rst_found_mask", 32'(found_mask), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // 2) directed table: two sweeps with cont=0
    tbl[0] = '{1, 0, 1, 0, 3'd2, 9'd100, 9'd50, '{2'd0, 1, 0, 3'd2, 9'd100, 9'd50, 0, 4'd0}};
    tbl[1] = '{0, 0, 1, 1, 3'd2, 9'd100, 9'd50, '{2'd1, 1, 0, 3'd2, 9'd100, 9'd50, 0, 4'd0}};
    tbl[2] = '{0, 0, 1, 0, 3'd2, 9'd100, 9'd50, '{2'd2, 1, 0, 3'd2, 9'd100, 9'd50, 1, 4'b0111}};
    tbl[3] = '{1, 1, 0, 0, 3'd6, 9'd11,  9'd22, '{2'd0, 0, 1, 3'd0, 9'd0,   9'd0,  0, 4'd0}};
    tbl[4] = '{0, 0, 3, 0, 3'd5, 9'd300, 9'd7,  '{2'd1, 1, 0, 3'd5, 9'd300, 9'd7,  0, 4'd0}};
    tbl[5] = '{0, 0, 2, 1, 3'd4, 9'd1,   9'd2,  '{2'd2, 0, 0, 3'd0, 9'd0,   9'd0,  1, 4'b0010}};
    cont_f = 1'b0;
    for (int r = 0; r < 6; r++) begin
      bit done;
      exp_q.push_back(tbl[r].e);
      pk_shape = tbl[r].sh; pk_x = tbl[r].x; pk_y = tbl[r].y;
      if (tbl[r].first) run_frame(1, 0, 0, FL, 0);
      for (int s = 0; s < SF; s++) run_frame(0, tbl[r].settle_pulse && (s == 0), 0, FL, 0);
      done = 1'b0;
      for (int j = 0; j < TF; j++) begin
        if (!done) begin
          if ((tbl[r].evt != 0) && (j == tbl[r].wf)) begin
            run_frame(0, tbl[r].evt[0], tbl[r].evt[1], FL, 0);
            done = 1'b1;
          end else begin
            run_frame(0, 0, 0, FL, 0);
          end
        end
      end
      if (!done) run_frame(0, 0, 0, FL, 0);
    end
    run_frame(0, 0, 0, FL, 0);
    chk("table_results_delivered", 32'(exp_q.size()), 32'd0);
    chk("idle_after_table", 32'(busy), 32'd0);

    // 3) invalid held high across a colour change
    pk_shape = 3'd0; pk_x = 9'd0; pk_y = 9'd0;
    push_exp(2'd0, 0, 0, 3'd0, 9'd0, 9'd0, 0, 4'd0);
    run_frame(1, 0, 0, FL, 0);
    run_frame(0, 0, 0, FL, 0);
    run_frame(0, 0, 0, 3, 0);          // invalid rises at cycle 3, stays high
    push_exp(2'd1, 0, 1, 3'd0, 9'd0, 9'd0, 0, 4'd0);
    run_frame(0, 0, 0, 0, 0);          // settle, still high
    run_frame(0, 0, 0, 0, 0);          // wait 0, no new edge
    run_frame(0, 0, 0, 0, 0);          // wait 1, times out at eop
    run_frame(0, 0, 0, FL, 0);         // invalid released
    push_exp(2'd2, 0, 0, 3'd0, 9'd0, 9'd0, 1, 4'd0);
    run_frame(0, 0, 0, FL, 0);
    run_frame(0, 0, 1, FL, 0);         // fresh invalid edge
    chk("held_invalid_results_delivered", 32'(exp_q.size()), 32'd0);

    // 4) cont=1 restart, ignored start, stop mid-WAIT at colour 1
    cont_f = 1'b1;
    pk_shape = 3'd3; pk_x = 9'd7; pk_y = 9'd9;
    push_exp(2'd0, 1, 0, 3'd3, 9'd7, 9'd9, 0, 4'd0);
    run_frame(1, 0, 0, FL, 0);
    run_frame(0, 0, 0, FL, 0);
    run_frame(0, 1, 0, FL, 0);
    push_exp(2'd1, 1, 0, 3'd3, 9'd7, 9'd9, 0, 4'd0);
    run_frame(1, 0, 0, FL, 0);         // start while busy
    run_frame(0, 1, 0, FL, 0);
    push_exp(2'd2, 1, 0, 3'd3, 9'd7, 9'd9, 1, 4'b0111);
    run_frame(0, 0, 0, FL, 0);
    run_frame(0, 1, 0, FL, 0);
    chk("cont_color_sel_wraps", 32'(color_sel), 32'd0);
    chk("cont_mask_cleared", 32'(found_mask), 32'd0);
    chk("cont_still_busy", 32'(busy), 32'd1);
    push_exp(2'd0, 1, 0, 3'd3, 9'd7, 9'd9, 0, 4'd0);
    run_frame(0, 0, 0, FL, 0);
    run_frame(0, 1, 0, FL, 0);
    cont_f = 1'b0;
    run_frame(0, 0, 0, FL, 0);         // settle of colour 1
    run_frame(0, 1, 0, FL, 1);         // stop at cycle 2, detect at cycle 3
    chk("stop_busy_low", 32'(busy), 32'd0);
    chk("stop_color_sel_held", 32'(color_sel), 32'd1);
    chk("stop_mask_held", 32'(found_mask), 32'b0001);
    run_frame(0, 1, 0, FL, 0);
    chk("stop_no_pending_results", 32'(exp_q.size()), 32'd0);

    // 5) reset mid-sweep
    pk_shape = 3'd1; pk_x = 9'd200; pk_y = 9'd33;
    push_exp(2'd0, 1, 0, 3'd1, 9'd200, 9'd33, 0, 4'd0);
    run_frame(1, 0, 0, FL, 0);
    run_frame(0, 0, 0, FL, 0);
    run_frame(0, 1, 0, FL, 0);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_color_sel", 32'(color_sel), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_res_vld", 32'(res_vld), 32'd0);
    chk("midrst_res_color", 32'(res_color), 32'd0);
    chk("midrst_res_found", 32'(res_found), 32'd0);
    chk("midrst_res_timeout", 32'(res_timeout), 32'd0);
    chk("midrst_res_shape", 32'(res_shape), 32'd0);
    chk("midrst_res_x", 32'(res_x), 32'd0);
    chk("midrst_res_y", 32'(res_y), 32'd0);
    chk("midrst_found_mask", 32'(found_mask), 32'd0);
    chk("midrst_sweep_done", 32'(sweep_done), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // 6) randomized frames against the frame-level model
    busy_chk_en = 1'b1;
    for (int f = 0; f < 230; f++) begin
      bit dp, ip, st;
      bool_quiet: begin end
      dp = ($urandom % 4) == 0;
      ip = ($urandom % 6) == 0;
      st = 1'b0;
      cont_f = ($urandom % 2) == 1;
      if (f >= 200) begin
        dp = 1'b0; ip = 1'b0; cont_f = 1'b0;
      end
      pk_shape = 3'($urandom); pk_x = 9'($urandom); pk_y = 9'($urandom);
      if (!m_act) begin
        if ((f < 200) && (($urandom % 2) == 1)) begin
          st = 1'b1; m_act = 1'b1; m_col = '0; m_mask = '0;
          m_skip = 1 + SF; m_win = 1'b0;
        end
      end else if (($urandom % 5) == 0) begin
        st = 1'b1;                     // start while busy is ignored
      end
      if (m_act && m_win && (dp || ip)) begin
        model_verdict(dp, 1'b0);
        m_win = 1'b0;
        m_skip = 1 + SF;
      end
      busy_exp = m_act;
      if (m_act) begin
        if (m_win) begin
          m_wfr++;
          if (m_wfr == TF) begin
            model_verdict(1'b0, 1'b1);
            m_win = 1'b0;
            m_skip = 1 + SF;           // next frame's eop is the change eop
          end
        end else begin
          m_skip--;
          if (m_skip == 0) begin
            m_win = 1'b1;
            m_wfr = 0;
          end
        end
      end
      run_frame(st, dp, ip, FL, 0);
    end
    busy_chk_en = 1'b0;
    run_frame(0, 0, 0, FL, 0);
    chk("random_results_delivered", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1);
  end

endmodule
